// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the byte-serial ALU sequencer: FSM states,
// command byte indices and the ALU opcodes used by callers.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } seq_state_t;

  localparam logic [2:0] IDX_OPCODE = 3'd0;
  localparam logic [2:0] IDX_A_LOW  = 3'd1;
  localparam logic [2:0] IDX_A_HIGH = 3'd2;
  localparam logic [2:0] IDX_B_LOW  = 3'd3;
  localparam logic [2:0] IDX_B_HIGH = 3'd4;

  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [7:0] ALU_EQ  = 8'h0A;

endpackage

// File: rtl/alu_sequencer_if.sv
// Byte-wide command input stream and result output stream of the sequencer.
interface alu_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_abort;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_overf;
  logic       out_zero;

  modport slave (
    input  in_data, in_valid, in_abort, out_ready,
    output in_ready, out_data, out_valid, out_overf, out_zero
  );

  modport master (
    output in_data, in_valid, in_abort, out_ready,
    input  in_ready, out_data, out_valid, out_overf, out_zero
  );
endinterface

// File: rtl/alu_seq_operand_regs.sv
// Write-indexed bank for opcode and operand bytes, with the byte counter
// and abort handling of a partially collected command.
module alu_seq_operand_regs
  import alu_sequencer_pkg::*;
#(
  parameter bit ABORT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       collect,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_abort,
  output logic [7:0] operation,
  output logic [7:0] a_low,
  output logic [7:0] a_high,
  output logic [7:0] b_low,
  output logic [7:0] b_high,
  output logic [2:0] byte_count,
  output logic       last_byte
);

  logic abort;
  logic accept;

  // Abort beats a simultaneous byte: the byte is dropped, not stored.
  assign abort     = ABORT_EN && collect && in_abort;
  assign accept    = collect && in_valid && !abort;
  assign last_byte = accept && (byte_count == IDX_B_HIGH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operation  <= '0;
      a_low      <= '0;
      a_high     <= '0;
      b_low      <= '0;
      b_high     <= '0;
      byte_count <= '0;
    end else if (abort) begin
      byte_count <= '0;
    end else if (accept) begin
      case (byte_count)
        IDX_OPCODE: operation <= in_data;
        IDX_A_LOW:  a_low     <= in_data;
        IDX_A_HIGH: a_high    <= in_data;
        IDX_B_LOW:  b_low     <= in_data;
        IDX_B_HIGH: b_high    <= in_data;
        default:    ;
      endcase
      byte_count <= last_byte ? '0 : byte_count + 3'd1;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Byte-serial front end for the 16-bit ALU: collects a command, holds the
// operands for a settle time, captures the result and streams it back.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          ABORT_EN      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_sequencer_if.slave   bus,
  output logic [7:0]       alu_operation,
  output logic [7:0]       alu_a_low,
  output logic [7:0]       alu_a_high,
  output logic [7:0]       alu_b_low,
  output logic [7:0]       alu_b_high,
  input  logic [7:0]       alu_res_low,
  input  logic [7:0]       alu_res_high,
  input  logic             alu_overf,
  output logic             busy
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("alu_sequencer: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  seq_state_t  state;
  logic [3:0]  settle;
  logic        settle_run;
  logic [15:0] result;
  logic        overf_q;
  logic        zero_q;
  logic [2:0]  byte_count;
  logic        last_byte;
  logic        collect;

  assign collect = (state == COLLECT);

  alu_seq_operand_regs #(
    .ABORT_EN (ABORT_EN)
  ) u_operand_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .collect    (collect),
    .in_data    (bus.in_data),
    .in_valid   (bus.in_valid),
    .in_abort   (bus.in_abort),
    .operation  (alu_operation),
    .a_low      (alu_a_low),
    .a_high     (alu_a_high),
    .b_low      (alu_b_low),
    .b_high     (alu_b_high),
    .byte_count (byte_count),
    .last_byte  (last_byte)
  );

  // The settle counter is loaded on the first ISSUE cycle, so capture lands
  // SETTLE_CYCLES+1 clocks after the last command byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= COLLECT;
      settle     <= '0;
      settle_run <= 1'b0;
      result     <= '0;
      overf_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (last_byte) begin
            state      <= ISSUE;
            settle_run <= 1'b0;
          end
        end
        ISSUE: begin
          if (!settle_run) begin
            settle_run <= 1'b1;
            settle     <= 4'(SETTLE_CYCLES - 1);
          end else if (settle == '0) begin
            result  <= {alu_res_high, alu_res_low};
            overf_q <= alu_overf;
            zero_q  <= ({alu_res_high, alu_res_low} == 16'h0000);
            state   <= SEND_LO;
          end else begin
            settle <= settle - 4'd1;
          end
        end
        SEND_LO: if (bus.out_ready) state <= SEND_HI;
        SEND_HI: if (bus.out_ready) state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = collect;
  assign bus.out_valid = (state == SEND_LO) || (state == SEND_HI);
  assign bus.out_data  = (state == SEND_HI) ? result[15:8] : result[7:0];
  assign bus.out_overf = overf_q;
  assign bus.out_zero  = zero_q;
  assign busy          = !(collect && (byte_count == IDX_OPCODE));

endmodule
